// File: rtl/axi_init_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_init_pkg
// Description : Shared types, AXI widths and constants for the AXI4 read
//               initiator: FSM state encoding, err bit positions, fixed
//               AR field values and the request legality check.
// Revision    : 1.0  initial release
// ============================================================================
package axi_init_pkg;

  // Bus widths
  localparam int AXI_ID_BITS   = 4;
  localparam int AXI_ADDR_BITS = 32;
  localparam int AXI_LEN_BITS  = 4;
  localparam int AXI_SIZE_BITS = 3;
  localparam int AXI_DATA_BITS = 32;

  // Output register payload: {last, data}
  localparam int OUT_PAYLOAD_BITS = AXI_DATA_BITS + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  // Bit positions inside the 4-bit err status
  localparam int ERR_RESP   = 0;
  localparam int ERR_ID     = 1;
  localparam int ERR_LEN    = 2;
  localparam int ERR_REJECT = 3;

  localparam logic [AXI_SIZE_BITS-1:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0]               BURST_INCR = 2'b01;
  localparam logic [1:0]               RESP_OKAY  = 2'b00;

  // A request is legal when word-aligned and the burst ends at or before the
  // next 4 KB page boundary. Only the in-page offset matters for either test.
  function automatic logic req_is_legal(input logic [11:0] offs,
                                        input logic [AXI_LEN_BITS-1:0] len);
    logic [12:0] end_offs;
    end_offs = {1'b0, offs} + {7'd0, len, 2'b00} + 13'd4;
    return (offs[1:0] == 2'b00) && (end_offs <= 13'd4096);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_read_initiator_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_if
// Description : AXI4 read address + read data channels.
//               master modport : drives AR*, RREADY
//               slave  modport : drives ARREADY, R*
// Revision    : 1.0  initial release
// ============================================================================
interface axi_rd_if;
  import axi_init_pkg::*;

  logic [AXI_ID_BITS-1:0]   ARID;
  logic [AXI_ADDR_BITS-1:0] ARADDR;
  logic [AXI_LEN_BITS-1:0]  ARLEN;
  logic [AXI_SIZE_BITS-1:0] ARSIZE;
  logic [1:0]               ARBURST;
  logic                     ARVALID;
  logic                     ARREADY;

  logic [AXI_ID_BITS-1:0]   RID;
  logic [AXI_DATA_BITS-1:0] RDATA;
  logic [1:0]               RRESP;
  logic                     RLAST;
  logic                     RVALID;
  logic                     RREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

endinterface
`default_nettype wire

// File: rtl/axi_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : axi_out_reg
// Description : Single-entry valid/ready pipeline register. Accepts a new
//               word whenever empty or being drained in the same cycle, so
//               a continuously ready consumer sees one word per cycle.
// Ports       : clk, rst_n        clock, synchronous active-low reset
//               in_valid/in_ready/in_data     upstream handshake
//               out_valid/out_ready/out_data  downstream handshake
// Revision    : 1.0  initial release
// ============================================================================
module axi_out_reg
  import axi_init_pkg::*;
#(
  parameter int WIDTH = OUT_PAYLOAD_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  assign in_ready  = !r_valid || out_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (in_valid && in_ready) begin
      // Load wins over drain: simultaneous load+drain keeps valid high
      r_valid <= 1'b1;
      r_data  <= in_data;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_read_initiator.sv
`default_nettype none
// ============================================================================
// Module      : axi_read_initiator
// Description : Single-outstanding AXI4 read master. Converts a burst request
//               (addr, len, id) into one AR transaction and streams the R
//               beats through a one-entry output register, checking RRESP,
//               RID and beat count. Illegal requests (misaligned or 4 KB
//               crossing) complete immediately with err[3].
// Ports       : clk, rst_n                       clock, sync active-low reset
//               req_valid/req_ready/req_addr/req_len/req_id   burst request
//               axi (axi_rd_if.master)           AXI4 AR + R channels
//               out_valid/out_ready/out_data/out_last         beat stream
//               done, err                        completion pulse + status
// Revision    : 1.0  initial release
// ============================================================================
module axi_read_initiator
  import axi_init_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [AXI_ADDR_BITS-1:0] req_addr,
  input  logic [AXI_LEN_BITS-1:0]  req_len,
  input  logic [AXI_ID_BITS-1:0]   req_id,

  axi_rd_if.master                 axi,

  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [AXI_DATA_BITS-1:0] out_data,
  output logic                     out_last,

  output logic                     done,
  output logic [3:0]               err
);

  state_t                   r_state;
  logic [AXI_ADDR_BITS-1:0] r_addr;
  logic [AXI_LEN_BITS-1:0]  r_len;
  logic [AXI_ID_BITS-1:0]   r_id;
  logic [AXI_SIZE_BITS-1:0] r_arsize;
  logic [1:0]               r_arburst;
  logic                     r_arvalid;
  logic [4:0]               r_cnt;
  logic [3:0]               r_err;
  logic                     r_done;

  logic                        w_buf_in_ready;
  logic                        w_rd_en;
  logic                        w_rready;
  logic                        w_r_hs;
  logic                        w_beat_is_final;
  logic                        w_drain_ok;
  logic [OUT_PAYLOAD_BITS-1:0] w_out_payload;

  assign w_rd_en         = (r_state == ST_DATA);
  assign w_rready        = w_rd_en && w_buf_in_ready;
  assign w_r_hs          = w_rready && axi.RVALID;
  // Beat index currently arriving is the one the length says should be last
  assign w_beat_is_final = (r_cnt == {1'b0, r_len});
  // Buffer empty now or emptying this cycle
  assign w_drain_ok      = !out_valid || out_ready;

  assign req_ready   = (r_state == ST_IDLE);
  assign axi.ARID    = r_id;
  assign axi.ARADDR  = r_addr;
  assign axi.ARLEN   = r_len;
  assign axi.ARSIZE  = r_arsize;
  assign axi.ARBURST = r_arburst;
  assign axi.ARVALID = r_arvalid;
  assign axi.RREADY  = w_rready;

  assign done     = r_done;
  assign err      = r_err;
  assign out_last = w_out_payload[AXI_DATA_BITS];
  assign out_data = w_out_payload[AXI_DATA_BITS-1:0];

  axi_out_reg #(
    .WIDTH (OUT_PAYLOAD_BITS)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_rd_en && axi.RVALID),
    .in_ready  (w_buf_in_ready),
    .in_data   ({axi.RLAST, axi.RDATA}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_payload)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_id      <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
      r_arvalid <= 1'b0;
      r_cnt     <= '0;
      r_err     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_addr    <= req_addr;
            r_len     <= req_len;
            r_id      <= req_id;
            r_arsize  <= SIZE_WORD;
            r_arburst <= BURST_INCR;
            r_cnt     <= '0;
            r_err     <= '0;
            if (!req_is_legal(req_addr[11:0], req_len)) begin
              // Rejected: done is raised on entry to FIN so it appears at N+1
              r_err[ERR_REJECT] <= 1'b1;
              r_done            <= 1'b1;
              r_state           <= ST_FIN;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= ST_ADDR;
            end
          end
        end

        ST_ADDR: begin
          if (axi.ARREADY) begin
            r_arvalid <= 1'b0;
            r_state   <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (w_r_hs) begin
            r_cnt <= r_cnt + 5'd1;
            if (axi.RRESP != RESP_OKAY) r_err[ERR_RESP] <= 1'b1;
            if (axi.RID != r_id)        r_err[ERR_ID]   <= 1'b1;
            // Early RLAST, or the expected final beat without RLAST. Beats
            // past the expected count keep being accepted until RLAST.
            if (axi.RLAST != w_beat_is_final) r_err[ERR_LEN] <= 1'b1;
            if (axi.RLAST) r_state <= ST_FIN;
          end
        end

        ST_FIN: begin
          // done is held off until the buffered final beat has left; the
          // state stays FIN for the done cycle so req_ready rises after it.
          if (r_done) begin
            r_state <= ST_IDLE;
          end else if (w_drain_ok) begin
            r_done <= 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_read_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_axi_read_initiator
// Description : Self-checking bench for axi_read_initiator. Acts as the AXI
//               read responder and the beat consumer; a scoreboard of beats
//               handed to the DUT and an error word derived from the
//               scenario give the expected outputs.
// Revision    : 1.0  initial release
// ============================================================================
module tb_axi_read_initiator;
  import axi_init_pkg::*;

  localparam logic [AXI_ID_BITS-1:0] ID_FLIP = 'd1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_len;
  logic [AXI_ID_BITS-1:0] req_id;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        done;
  logic [3:0]  err;

  int n_cmp  = 0;
  int n_fail = 0;

  axi_rd_if axi ();

  axi_read_initiator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_id    (req_id),
    .axi       (axi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    req_valid   = 1'b0;
    req_addr    = '0;
    req_len     = '0;
    req_id      = '0;
    out_ready   = 1'b1;
    axi.ARREADY = 1'b0;
    axi.RVALID  = 1'b0;
    axi.RID     = '0;
    axi.RDATA   = '0;
    axi.RRESP   = 2'b00;
    axi.RLAST   = 1'b0;
  endtask

  // Runs one accepted burst. n_beats beats are returned, RLAST on the final
  // one; bad_beat (if >=0) gets SLVERR; bad_id flips RID. stall_mode:
  // 0 consumer always ready, 1 alternating, 2 random. Cycle numbers are
  // relative to the request handshake (period 1 = first cycle after it).
  task automatic run_burst(input logic [31:0] addr, input logic [3:0] len,
                           input logic [AXI_ID_BITS-1:0] id, input int n_beats,
                           input int bad_beat, input bit bad_id,
                           input int stall_mode, input int ar_delay,
                           input bit r_gaps, output int done_cyc,
                           output int first_out, output int last_out);
    logic [31:0] data[$];
    logic [32:0] exp_q[$];
    logic [32:0] exp_beat;
    logic [3:0]  exp_err;
    int  c, sent, got, arv_seen;
    bit  ar_hs, finished, r_took;

    for (int i = 0; i < n_beats; i++) data.push_back($urandom);
    exp_err = 4'b0000;
    if (bad_beat >= 0 && bad_beat < n_beats) exp_err[0] = 1'b1;
    if (bad_id) exp_err[1] = 1'b1;
    if (n_beats != int'(len) + 1) exp_err[2] = 1'b1;

    done_cyc = -1; first_out = -1; last_out = -1;
    sent = 0; got = 0; arv_seen = 0; ar_hs = 0; finished = 0; r_took = 0;

    axi.RVALID = 1'b0;
    req_valid = 1'b1; req_addr = addr; req_len = len; req_id = id;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL req_ready_idle: got %b want 1", req_ready);
    end
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    c = 1;

    while (!finished && c < 400) begin
      // drive responder and consumer
      axi.ARREADY = (arv_seen >= ar_delay);
      if (!axi.RVALID || r_took) begin
        if (ar_hs && sent < n_beats && (!r_gaps || $urandom_range(0, 2) != 0)) begin
          axi.RVALID = 1'b1;
          axi.RDATA  = data[sent];
          axi.RID    = bad_id ? (id ^ ID_FLIP) : id;
          axi.RRESP  = (sent == bad_beat) ? 2'b10 : 2'b00;
          axi.RLAST  = (sent == n_beats - 1);
        end else begin
          axi.RVALID = 1'b0;
          axi.RLAST  = 1'b0;
        end
      end
      r_took = 0;
      case (stall_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (c % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;

      // address channel
      n_cmp++;
      if (axi.ARVALID !== !ar_hs) begin
        n_fail++; $display("FAIL arvalid c=%0d: got %b want %b", c, axi.ARVALID, !ar_hs);
      end
      if (!ar_hs) begin
        n_cmp++;
        if ({axi.ARADDR, axi.ARLEN, axi.ARID, axi.ARSIZE, axi.ARBURST} !==
            {addr, len, id, 3'b010, 2'b01}) begin
          n_fail++;
          $display("FAIL ar_fields: got addr=%h len=%0d id=%0d size=%b burst=%b want addr=%h len=%0d id=%0d size=010 burst=01",
                   axi.ARADDR, axi.ARLEN, axi.ARID, axi.ARSIZE, axi.ARBURST, addr, len, id);
        end
        if (axi.ARREADY) ar_hs = 1; else arv_seen++;
      end

      // backpressure: a full buffer with a stalled consumer must block R
      if (out_valid && !out_ready) begin
        n_cmp++;
        if (axi.RREADY !== 1'b0) begin
          n_fail++; $display("FAIL rready_stall c=%0d: got %b want 0", c, axi.RREADY);
        end
      end

      if (axi.RVALID && axi.RREADY) begin
        exp_q.push_back({sent == n_beats - 1, data[sent]});
        sent++;
        r_took = 1;
      end

      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL out_spurious c=%0d: got data %h want none", c, out_data);
        end else begin
          exp_beat = exp_q.pop_front();
          if ({out_last, out_data} !== exp_beat) begin
            n_fail++;
            $display("FAIL out_beat %0d: got last=%b data=%h want last=%b data=%h",
                     got, out_last, out_data, exp_beat[32], exp_beat[31:0]);
          end
        end
        if (first_out < 0) first_out = c;
        last_out = c;
        got++;
      end

      if (done) begin
        n_cmp++;
        if (err !== exp_err) begin
          n_fail++; $display("FAIL done_err: got %b want %b", err, exp_err);
        end
        n_cmp++;
        if (got != n_beats || sent != n_beats || exp_q.size() != 0) begin
          n_fail++; $display("FAIL beat_count: got %0d out/%0d sent want %0d", got, sent, n_beats);
        end
        n_cmp++;
        if (done_cyc_ok(c, last_out) == 0) begin
          n_fail++; $display("FAIL done_order: got done c=%0d last out c=%0d want done later", c, last_out);
        end
        done_cyc = c;
        finished = 1;
      end

      @(posedge clk); @(negedge clk);
      c++;
    end

    axi.RVALID = 1'b0; axi.RLAST = 1'b0; out_ready = 1'b1;
    if (!finished) begin
      n_cmp++; n_fail++;
      $display("FAIL burst_timeout: got no done after %0d cycles want done", c);
    end else begin
      #1;
      n_cmp++;
      if ({done, req_ready} !== 2'b01) begin
        n_fail++; $display("FAIL after_done: got done=%b req_ready=%b want 0 1", done, req_ready);
      end
    end
  endtask

  function automatic int done_cyc_ok(input int dc, input int lo);
    return (dc > lo) ? 1 : 0;
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_cmp++;
    if ({axi.ARVALID, axi.RREADY, out_valid, done} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {axi.ARVALID, axi.RREADY, out_valid, done});
    end
    n_cmp++;
    if (err !== 4'b0000) begin
      n_fail++; $display("FAIL reset_err: got %b want 0000", err);
    end
    n_cmp++;
    if ({axi.ARADDR, axi.ARID, axi.ARLEN, axi.ARSIZE, axi.ARBURST} !== '0) begin
      n_fail++; $display("FAIL reset_ar: got addr=%h id=%0d len=%0d size=%b burst=%b want zeros",
                         axi.ARADDR, axi.ARID, axi.ARLEN, axi.ARSIZE, axi.ARBURST);
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    n_cmp++;
    if ({req_ready, axi.ARVALID, done} !== 3'b100) begin
      n_fail++; $display("FAIL post_reset: got %b want 100", {req_ready, axi.ARVALID, done});
    end
  endtask

  task automatic test_basic();
    int d, f, l;
    run_burst(32'h0000_1000, 4'd3, 4'd2, 4, -1, 0, 0, 0, 0, d, f, l);
    n_cmp++;
    if (f != 3 || l != 6) begin
      n_fail++; $display("FAIL basic_stream: got first=%0d last=%0d want 3 6", f, l);
    end
    n_cmp++;
    if (d != 7) begin
      n_fail++; $display("FAIL basic_done_cycle: got %0d want 7", d);
    end
  endtask

  task automatic test_min_turnaround();
    int d, f, l;
    run_burst(32'h0000_2040, 4'd0, 4'd9, 1, -1, 0, 0, 0, 0, d, f, l);
    n_cmp++;
    if (f != 3 || d != 4) begin
      n_fail++; $display("FAIL min_turnaround: got out=%0d done=%0d want 3 4", f, d);
    end
  endtask

  task automatic test_backpressure();
    int d, f, l;
    run_burst(32'h0000_1000, 4'd3, 4'd2, 4, -1, 0, 1, 2, 0, d, f, l);
    run_burst(32'h0003_0100, 4'd7, 4'd6, 8, -1, 0, 2, 1, 1, d, f, l);
  endtask

  task automatic test_error_cases();
    int d, f, l;
    run_burst(32'h0000_1000, 4'd3, 4'd1, 4, 2, 0, 0, 0, 0, d, f, l);  // SLVERR on beat 2
    run_burst(32'h0000_1000, 4'd3, 4'd1, 2, -1, 0, 0, 0, 0, d, f, l); // RLAST on beat 1
    run_burst(32'h0000_1000, 4'd3, 4'd3, 4, -1, 1, 0, 0, 0, d, f, l); // wrong RID
    run_burst(32'h0000_5000, 4'd2, 4'd4, 5, -1, 0, 2, 0, 0, d, f, l); // RLAST late
  endtask

  task automatic test_reject(input logic [31:0] addr, input logic [3:0] len);
    idle_inputs();
    req_valid = 1'b1; req_addr = addr; req_len = len; req_id = 4'd7;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    #1;
    n_cmp++;
    if ({axi.ARVALID, done, err} !== 6'b01_1000) begin
      n_fail++; $display("FAIL reject %h: got arvalid=%b done=%b err=%b want 0 1 1000",
                         addr, axi.ARVALID, done, err);
    end
    @(posedge clk); @(negedge clk); #1;
    n_cmp++;
    if ({axi.ARVALID, done, req_ready} !== 3'b001) begin
      n_fail++; $display("FAIL reject_after %h: got arvalid=%b done=%b req_ready=%b want 0 0 1",
                         addr, axi.ARVALID, done, req_ready);
    end
  endtask

  task automatic test_page_edge();
    int d, f, l;
    // ends exactly on the 4 KB boundary: must be accepted
    run_burst(32'h0000_0FC0, 4'd15, 4'd5, 16, -1, 0, 0, 0, 0, d, f, l);
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    axi.ARREADY = 1'b1;
    req_valid = 1'b1; req_addr = 32'h0000_2000; req_len = 4'd3; req_id = 4'd5;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      axi.RVALID = 1'b1; axi.RDATA = $urandom; axi.RID = 4'd5;
      axi.RRESP = 2'b00; axi.RLAST = 1'b0;
      if (b == 2) begin
        #1;
        n_cmp++;
        if ({out_valid, axi.RREADY} !== 2'b11) begin
          n_fail++; $display("FAIL mid_burst_pre: got out_valid=%b rready=%b want 1 1", out_valid, axi.RREADY);
        end
        rst_n = 1'b0;
      end
      @(posedge clk); @(negedge clk);
    end
    #1;
    n_cmp++;
    if ({axi.ARVALID, axi.RREADY, out_valid, done, err, req_ready} !== 9'b0000_0000_1) begin
      n_fail++; $display("FAIL mid_reset: got arv=%b rr=%b ov=%b done=%b err=%b rq=%b want 0 0 0 0 0000 1",
                         axi.ARVALID, axi.RREADY, out_valid, done, err, req_ready);
    end
    n_cmp++;
    if ({axi.ARADDR, axi.ARLEN, axi.ARID} !== '0) begin
      n_fail++; $display("FAIL mid_reset_ar: got addr=%h len=%0d id=%0d want 0", axi.ARADDR, axi.ARLEN, axi.ARID);
    end
    axi.RVALID = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_random();
    int d, f, l, off, nb, bad, k;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [AXI_ID_BITS-1:0] id;
    bit bid;
    for (int t = 0; t < 30; t++) begin
      len  = 4'($urandom_range(0, 15));
      off  = int'($urandom_range(0, (4096 - 4 * (int'(len) + 1)) / 4)) * 4;
      addr = ($urandom & 32'hFFFF_F000) | 32'(off);
      id   = AXI_ID_BITS'($urandom);
      nb   = int'(len) + 1;
      k    = int'($urandom_range(0, 7));
      if (k == 0) nb = int'($urandom_range(1, int'(len) + 1));
      if (k == 1) nb = int'(len) + 2;
      bad  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      bid  = ($urandom_range(0, 4) == 0);
      run_burst(addr, len, id, nb, bad, bid, 2, int'($urandom_range(0, 3)), 1, d, f, l);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_min_turnaround();
    test_backpressure();
    test_error_cases();
    test_reject(32'h0000_0FF8, 4'd3);
    test_reject(32'h0000_1002, 4'd3);
    test_page_edge();
    test_reset_mid();
    test_basic();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
